// File: rtl/div_32_16_seq_pkg.sv
// Shared types and default sizes for the sequential 32/16 restoring divider.
package div_pkg;

    localparam int AW_DEF = 32;              // dividend / quotient width
    localparam int BW_DEF = 16;              // divisor / remainder width
    localparam int CW     = $clog2(AW_DEF);  // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_32_16_seq_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int BW = div_pkg::BW_DEF
) (
    input  logic [BW-1:0] i_rem,
    input  logic          i_bit,
    input  logic [BW-1:0] i_div,
    output logic [BW-1:0] o_rem,
    output logic          o_qbit
);

    logic [BW:0] w_sh;
    logic [BW:0] w_diff;

    // Shifted partial remainder and trial subtraction.
    // The result is kept to BW bits: with a nonzero divisor it is always
    // below the divisor, and with a zero divisor only the low BW bits
    // ever feed the next step or the final remainder.
    always_comb begin
        w_sh   = {i_rem, i_bit};
        w_diff = w_sh - {1'b0, i_div};
        o_qbit = (w_sh >= {1'b0, i_div});
        o_rem  = o_qbit ? BW'(w_diff) : BW'(w_sh);
    end

endmodule

// File: rtl/div_32_16_seq.sv
// Sequential restoring divider: AW-bit unsigned dividend by BW-bit unsigned
// divisor, one quotient bit per clock, fixed AW+1 edge latency.
module div_32_16_seq
    import div_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int BW = BW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] A,
    input  logic [BW-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] Q,
    output logic [BW-1:0] R,
    output logic          dbz
);

    localparam int LCW = $clog2(AW);
    localparam logic [LCW-1:0] LAST = LCW'(AW - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_last;

    logic [AW-1:0]  r_a;
    logic [BW-1:0]  r_b;
    logic [BW-1:0]  r_rem;
    logic [AW-1:0]  r_q;
    logic [LCW-1:0] r_cnt;

    logic [AW-1:0]  r_q_out;
    logic [BW-1:0]  r_r_out;
    logic           r_dbz;

    logic [LCW-1:0] w_idx;
    logic [BW-1:0]  w_rem_nxt;
    logic           w_qbit;
    logic [AW-1:0]  w_q_nxt;

    // Bits are consumed MSB first: cycle cnt handles dividend bit AW-1-cnt.
    assign w_idx   = LAST - r_cnt;
    assign w_last  = (r_cnt == LAST);
    assign w_q_nxt = (r_q << 1) | AW'(w_qbit);

    div_step #(.BW(BW)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_a[w_idx]),
        .i_div  (r_b),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; a start is only taken when not iterating.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_q_out <= '0;
            r_r_out <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            if (w_last) begin
                // Counter parks at zero instead of wrapping past the terminal count.
                r_cnt   <= '0;
                r_q_out <= w_q_nxt;
                r_r_out <= w_rem_nxt;
                r_dbz   <= (r_b == '0);
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign Q   = r_q_out;
    assign R   = r_r_out;
    assign dbz = r_dbz;

endmodule

// File: tb/tb_div_32_16_seq.sv
// Self-checking bench for div_32_16_seq with an expected-result scoreboard.
module tb_div_32_16_seq;

    localparam int AW = 32;
    localparam int BW = 16;

    typedef struct packed {
        logic [AW-1:0] q;
        logic [BW-1:0] r;
        logic          dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] A = '0;
    logic [BW-1:0] B = '0;
    logic          busy, done, dbz;
    logic [AW-1:0] Q;
    logic [BW-1:0] R;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    div_32_16_seq #(.AW(AW), .BW(BW)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [AW-1:0] a, input logic [BW-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a[BW-1:0];
            e.dbz = 1'b1;
        end else begin
            e.q = a / AW'(b);
            e.r = BW'(a % AW'(b));
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Drive one start pulse; returns 1 ns after the accepting edge.
    task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b);
        @(negedge clk);
        start = 1'b1; A = a; B = b;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = BW'($urandom);
    endtask

    // Step edges until done is seen (bounded); counts edges and busy samples.
    task automatic wait_done(output int edges, output int busy_n, output bit both);
        edges = 0; busy_n = 0; both = 1'b0;
        while (done !== 1'b1 && edges < 100) begin
            if (busy === 1'b1) busy_n++;
            if (busy === 1'b1 && done === 1'b1) both = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        if (busy === 1'b1 && done === 1'b1) both = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, dbz} !== 3'b000 || Q !== '0 || R !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%0b done=%0b dbz=%0b Q=%0h R=%0h, required all 0", busy, done, dbz, Q, R);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_basic();
        int e, bn; bit both; exp_t x;
        issue(32'd100, 16'd7);
        wait_done(e, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || e != AW) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d edges past accept, required %0d", e, AW);
        end
        n_checks++;
        if (bn != AW || both) begin
            n_fail++;
            $display("FAIL basic_busy: busy cycles %0d overlap=%0b, required %0d overlap=0", bn, both, AW);
        end
        n_checks++;
        if (Q !== x.q || R !== x.r || dbz !== x.dbz) begin
            n_fail++;
            $display("FAIL basic_result: Q=%0d R=%0d dbz=%0b, required Q=%0d R=%0d dbz=%0b", Q, R, dbz, x.q, x.r, x.dbz);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: done=%0b busy=%0b after done cycle, required 0 0", done, busy);
        end
        repeat (5) @(posedge clk); #1;
        n_checks++;
        if (Q !== 32'd14 || R !== 16'd2) begin
            n_fail++;
            $display("FAIL basic_hold: Q=%0d R=%0d in idle, required 14 2", Q, R);
        end
    endtask

    task automatic test_inverse();
        int e, bn; bit both; exp_t x;
        logic [AW-1:0] av [2];
        logic [BW-1:0] bv [2];
        av[0] = 32'hFFFF_FFFF; bv[0] = 16'hFFFF;
        av[1] = 32'hFFFF_FFFF; bv[1] = 16'h0001;
        for (int k = 0; k < 2; k++) begin
            issue(av[k], bv[k]);
            wait_done(e, bn, both);
            x = sb.pop_front();
            n_checks++;
            if (done !== 1'b1 || Q !== x.q || R !== x.r || dbz !== 1'b0) begin
                n_fail++;
                $display("FAIL inverse_%0d: done=%0b Q=%0h R=%0h dbz=%0b, required 1 Q=%0h R=%0h dbz=0", k, done, Q, R, dbz, x.q, x.r);
            end
        end
        // Product of random 16x16 operands must divide back exactly.
        for (int k = 0; k < 4; k++) begin
            logic [15:0] ma, mb;
            ma = 16'($urandom); mb = 16'($urandom_range(1, 65535));
            issue(AW'(ma) * AW'(mb), mb);
            wait_done(e, bn, both);
            x = sb.pop_front();
            n_checks++;
            if (done !== 1'b1 || Q !== AW'(ma) || R !== '0 || Q !== x.q) begin
                n_fail++;
                $display("FAIL product_%0d: Q=%0h R=%0h, required Q=%0h R=0", k, Q, R, ma);
            end
        end
    endtask

    task automatic test_dbz();
        int e, bn; bit both; exp_t x;
        issue(32'h0000_1234, 16'h0000);
        wait_done(e, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || e != AW) begin
            n_fail++;
            $display("FAIL dbz_latency: done after %0d edges, required %0d", e, AW);
        end
        n_checks++;
        if (Q !== 32'hFFFF_FFFF || R !== 16'h1234 || dbz !== 1'b1 || Q !== x.q || R !== x.r) begin
            n_fail++;
            $display("FAIL dbz_result: Q=%0h R=%0h dbz=%0b, required Q=ffffffff R=1234 dbz=1", Q, R, dbz);
        end
    endtask

    task automatic test_start_during_run();
        int e, bn, extra; bit both; exp_t x;
        issue(32'd100, 16'd7);
        repeat (9) begin @(posedge clk); #1; end
        start = 1'b1; A = 32'd9; B = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(e, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || e + 10 != AW) begin
            n_fail++;
            $display("FAIL run_start_latency: done after %0d edges, required %0d", e + 10, AW);
        end
        n_checks++;
        if (Q !== x.q || R !== x.r || Q !== 32'd14) begin
            n_fail++;
            $display("FAIL run_start_result: Q=%0d R=%0d, required Q=14 R=2", Q, R);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL run_start_once: %0d extra done pulses, required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, bn; bit both; exp_t x;
        @(negedge clk);
        start = 1'b1; A = 32'd50; B = 16'd5;
        sb.push_back(model(32'd50, 16'd5));
        @(posedge clk); #1;
        A = 32'd51;
        sb.push_back(model(32'd51, 16'd5));
        wait_done(e1, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || Q !== x.q || R !== x.r) begin
            n_fail++;
            $display("FAIL b2b_first: done=%0b Q=%0d R=%0d, required 1 Q=%0d R=%0d", done, Q, R, x.q, x.r);
        end
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || Q !== 32'd10 || R !== 16'd0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%0b Q=%0d R=%0d, required busy=1 Q=10 R=0", busy, Q, R);
        end
        wait_done(e2, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || e2 + 1 != AW + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: done pulses %0d edges apart, required %0d", e2 + 1, AW + 1);
        end
        n_checks++;
        if (Q !== x.q || R !== x.r || R !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_second: Q=%0d R=%0d, required Q=%0d R=%0d", Q, R, x.q, x.r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int e, bn; bit both; exp_t x;
        issue(32'd100, 16'd7);
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, dbz} !== 3'b000 || Q !== '0 || R !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%0b done=%0b dbz=%0b Q=%0h R=%0h, required all 0", busy, done, dbz, Q, R);
        end
        rst = 1'b0;
        sb.delete();
        issue(32'd200, 16'd9);
        wait_done(e, bn, both);
        x = sb.pop_front();
        n_checks++;
        if (done !== 1'b1 || e != AW || Q !== x.q || R !== x.r || dbz !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_recover: edges=%0d Q=%0d R=%0d, required edges=%0d Q=%0d R=%0d", e, Q, R, AW, x.q, x.r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_dbz();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
